// File: rtl/axis_width_packer_pkg.sv
// Shared definitions for the narrow-to-wide AXI4-Stream packer.
//   COMP_DATA_BITS : default narrow (compression-core) tdata width
//   AXI_DATA_BITS  : default wide (host/FIFO) tdata width
//   KEEP_MAX_BITS  : widest tkeep keep_popcount() can count
//   ratio_of()     : wide/narrow lane ratio for localparam derivation
//   keep_popcount(): number of set tkeep bits (valid bytes in a beat)
package axis_width_packer_pkg;

  localparam int COMP_DATA_BITS = 64;
  localparam int AXI_DATA_BITS  = 512;
  localparam int KEEP_MAX_BITS  = 256;

  function automatic int unsigned ratio_of(input int unsigned out_bits,
                                           input int unsigned in_bits);
    return (in_bits == 0) ? 0 : out_bits / in_bits;
  endfunction

  function automatic int unsigned keep_popcount(input logic [KEEP_MAX_BITS-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEEP_MAX_BITS; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational byte counter for one narrow beat's tkeep.
//   keep  in  KEEP_BITS   tkeep of the beat
//   count out COUNT_BITS  number of valid bytes (set keep bits)
module axis_keep_popcount
  import axis_width_packer_pkg::*;
#(
  parameter int KEEP_BITS  = COMP_DATA_BITS / 8,
  parameter int COUNT_BITS = $clog2(KEEP_BITS + 1)
) (
  input  logic [KEEP_BITS-1:0]  keep,
  output logic [COUNT_BITS-1:0] count
);

  if (KEEP_BITS > KEEP_MAX_BITS) begin : g_keep_too_wide
    $error("axis_keep_popcount: KEEP_BITS exceeds KEEP_MAX_BITS");
  end

  assign count = COUNT_BITS'(keep_popcount(KEEP_MAX_BITS'(keep)));

endmodule

// File: rtl/axis_width_packer.sv
// Packs a narrow AXI4-Stream into wide beats, lane 0 at the LSB.
// A wide beat closes when all lanes are filled or on tlast; unused lanes
// carry tkeep=0/tdata=0. Counts the bytes of each packet (saturating).
//   clk, rst_n                single clock, synchronous active-low reset
//   axis_in_*   (slave)       narrow input: tdata, tkeep, tlast, tvalid, tready
//   axis_out_*  (master)      wide output:  tdata, tkeep, tlast, tvalid, tready
//   o_pkt_bytes out CNT_BITS  byte count of the packet just completed
//   o_pkt_valid out 1         one-cycle strobe qualifying o_pkt_bytes
module axis_width_packer
  import axis_width_packer_pkg::*;
#(
  parameter int IN_BITS  = COMP_DATA_BITS,
  parameter int OUT_BITS = AXI_DATA_BITS,
  parameter int CNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_BITS-1:0]    axis_in_tdata,
  input  logic [IN_BITS/8-1:0]  axis_in_tkeep,
  input  logic                  axis_in_tlast,
  input  logic                  axis_in_tvalid,
  output logic                  axis_in_tready,
  output logic [OUT_BITS-1:0]   axis_out_tdata,
  output logic [OUT_BITS/8-1:0] axis_out_tkeep,
  output logic                  axis_out_tlast,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready,
  output logic [CNT_BITS-1:0]   o_pkt_bytes,
  output logic                  o_pkt_valid
);

  localparam int RATIO    = int'(ratio_of(OUT_BITS, IN_BITS));
  localparam int IN_KEEP  = IN_BITS / 8;
  localparam int OUT_KEEP = OUT_BITS / 8;
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int POP_W    = $clog2(IN_KEEP + 1);

  if (IN_BITS % 8 != 0) begin : g_bad_in_bits
    $error("axis_width_packer: IN_BITS must be a multiple of 8");
  end
  if (OUT_BITS % IN_BITS != 0) begin : g_bad_ratio
    $error("axis_width_packer: OUT_BITS must be a multiple of IN_BITS");
  end

  logic [LANE_W-1:0]   lane_q;
  logic [OUT_BITS-1:0] build_data_q;
  logic [OUT_KEEP-1:0] build_keep_q;
  logic [CNT_BITS-1:0] acc_q;

  logic                in_fire;
  logic                out_fire;
  logic                pkt_end_fire;
  logic                lane_write;
  logic                beat_done;
  logic [OUT_BITS-1:0] merged_data;
  logic [OUT_KEEP-1:0] merged_keep;
  logic [POP_W-1:0]    in_pop;
  logic [CNT_BITS-1:0] acc_base;
  logic [CNT_BITS:0]   acc_sum;
  logic [CNT_BITS-1:0] acc_next;

  axis_keep_popcount #(
    .KEEP_BITS  (IN_KEEP),
    .COUNT_BITS (POP_W)
  ) u_keep_popcount (
    .keep  (axis_in_tkeep),
    .count (in_pop)
  );

  // The only stall source is a held, unaccepted wide beat; a handoff in the
  // same cycle frees the output register for the next completing beat.
  assign axis_in_tready = !axis_out_tvalid || axis_out_tready;
  assign in_fire        = axis_in_tvalid && axis_in_tready;
  assign out_fire       = axis_out_tvalid && axis_out_tready;
  assign pkt_end_fire   = out_fire && axis_out_tlast;

  // A tkeep==0 beat never occupies a lane; with tlast it only closes the beat.
  assign lane_write = in_fire && (axis_in_tkeep != '0);
  assign beat_done  = in_fire &&
                      (axis_in_tlast || (lane_write && lane_q == LANE_W'(RATIO - 1)));

  // Current partial beat with the incoming lane merged in. Lanes above the
  // write position are still zero because the build registers are cleared
  // every time a wide beat is handed to the output register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    merged_data = build_data_q;
    merged_keep = build_keep_q;
    if (lane_write) begin
      for (int l = 0; l < RATIO; l++) begin
        if (lane_q == LANE_W'(l)) begin
          merged_data[l*IN_BITS +: IN_BITS] = axis_in_tdata;
          merged_keep[l*IN_KEEP +: IN_KEEP] = axis_in_tkeep;
        end
      end
    end
  end

  // A packet closing on the output this cycle hands its total over, so a
  // beat of the next packet accepted in the same cycle starts from zero.
  always_comb begin
    acc_base = pkt_end_fire ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (CNT_BITS + 1)'(in_pop);
    acc_next = acc_sum[CNT_BITS] ? '1 : acc_sum[CNT_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the build registers are datapath, but they are reset anyway:
      // the zero-padding of unused lanes relies on them starting from zero.
      lane_q          <= '0;
      build_data_q    <= '0;
      build_keep_q    <= '0;
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      acc_q           <= '0;
      o_pkt_bytes     <= '0;
      o_pkt_valid     <= 1'b0;
    end else begin
      if (out_fire) axis_out_tvalid <= 1'b0;

      if (beat_done) begin
        axis_out_tvalid <= 1'b1;
        axis_out_tdata  <= merged_data;
        axis_out_tkeep  <= merged_keep;
        axis_out_tlast  <= axis_in_tlast;
        build_data_q    <= '0;
        build_keep_q    <= '0;
        lane_q          <= '0;
      end else if (lane_write) begin
        build_data_q    <= merged_data;
        build_keep_q    <= merged_keep;
        lane_q          <= lane_q + LANE_W'(1);
      end

      o_pkt_valid <= pkt_end_fire;
      if (pkt_end_fire) o_pkt_bytes <= acc_q;

      if (in_fire)           acc_q <= acc_next;
      else if (pkt_end_fire) acc_q <= '0;
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// Self-checking bench for axis_width_packer: a 64->512 instance checked
// against a queue-based packet model, a 64->64 instance for the pass-through
// case and a CNT_BITS=8 instance for counter saturation.
module tb_axis_width_packer;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } wide_t;

  logic clk;
  logic rst_n;

  // main instance, 64 -> 512
  logic [63:0]  in_tdata;
  logic [7:0]   in_tkeep;
  logic         in_tlast, in_tvalid, in_tready;
  logic [511:0] out_tdata;
  logic [63:0]  out_tkeep;
  logic         out_tlast, out_tvalid, out_tready;
  logic [31:0]  pkt_bytes;
  logic         pkt_valid;

  // pass-through instance, 64 -> 64
  logic [63:0]  r1_in_tdata;
  logic [7:0]   r1_in_tkeep;
  logic         r1_in_tlast, r1_in_tvalid, r1_in_tready;
  logic [63:0]  r1_out_tdata;
  logic [7:0]   r1_out_tkeep;
  logic         r1_out_tlast, r1_out_tvalid, r1_out_tready;
  logic [31:0]  r1_pkt_bytes;
  logic         r1_pkt_valid;

  // saturation instance, 64 -> 512, 8-bit counter
  logic [63:0]  sat_in_tdata;
  logic [7:0]   sat_in_tkeep;
  logic         sat_in_tlast, sat_in_tvalid, sat_in_tready;
  logic [511:0] sat_out_tdata;
  logic [63:0]  sat_out_tkeep;
  logic         sat_out_tlast, sat_out_tvalid, sat_out_tready;
  logic [7:0]   sat_pkt_bytes;
  logic         sat_pkt_valid;

  axis_width_packer #(.IN_BITS(64), .OUT_BITS(512), .CNT_BITS(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tlast(out_tlast),
    .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
    .o_pkt_bytes(pkt_bytes), .o_pkt_valid(pkt_valid)
  );

  axis_width_packer #(.IN_BITS(64), .OUT_BITS(64), .CNT_BITS(32)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tdata(r1_in_tdata), .axis_in_tkeep(r1_in_tkeep), .axis_in_tlast(r1_in_tlast),
    .axis_in_tvalid(r1_in_tvalid), .axis_in_tready(r1_in_tready),
    .axis_out_tdata(r1_out_tdata), .axis_out_tkeep(r1_out_tkeep), .axis_out_tlast(r1_out_tlast),
    .axis_out_tvalid(r1_out_tvalid), .axis_out_tready(r1_out_tready),
    .o_pkt_bytes(r1_pkt_bytes), .o_pkt_valid(r1_pkt_valid)
  );

  axis_width_packer #(.IN_BITS(64), .OUT_BITS(512), .CNT_BITS(8)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tdata(sat_in_tdata), .axis_in_tkeep(sat_in_tkeep), .axis_in_tlast(sat_in_tlast),
    .axis_in_tvalid(sat_in_tvalid), .axis_in_tready(sat_in_tready),
    .axis_out_tdata(sat_out_tdata), .axis_out_tkeep(sat_out_tkeep), .axis_out_tlast(sat_out_tlast),
    .axis_out_tvalid(sat_out_tvalid), .axis_out_tready(sat_out_tready),
    .o_pkt_bytes(sat_pkt_bytes), .o_pkt_valid(sat_pkt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (packet-level, queue based) ----------------
  wide_t       exp_q[$];
  longint      exp_bytes_q[$];
  logic [63:0] m_lane_data[$];
  logic [7:0]  m_lane_keep[$];
  longint      m_bytes;

  task automatic model_reset();
    m_lane_data.delete();
    m_lane_keep.delete();
    m_bytes = 0;
  endtask

  task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    wide_t w;
    m_bytes += longint'($countones(k));
    if (k != 8'h00) begin
      m_lane_data.push_back(d);
      m_lane_keep.push_back(k);
    end
    if (m_lane_data.size() == 8 || l) begin
      w = '0;
      for (int i = 0; i < m_lane_data.size(); i++) begin
        w.data[i*64 +: 64] = m_lane_data[i];
        w.keep[i*8 +: 8]   = m_lane_keep[i];
      end
      w.last = l;
      exp_q.push_back(w);
      m_lane_data.delete();
      m_lane_keep.delete();
      if (l) begin
        exp_bytes_q.push_back(m_bytes > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_bytes);
        m_bytes = 0;
      end
    end
  endtask

  // ---------------- sink and monitors ----------------
  bit           rand_ready = 0;
  int           n_out  = 0;
  int           n_pkt  = 0;
  logic [511:0] last_data;
  logic [63:0]  last_keep;
  logic         last_last;
  logic [31:0]  last_bytes;

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : main_monitor
    wide_t w;
    logic  stalled_prev;
    stalled_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) check("stall_hold_valid", 512'(out_tvalid), 512'(1));
        if (out_tvalid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 512'(out_tvalid), 512'(0));
          end else begin
            w = exp_q[0];
            check("out_tdata", out_tdata, w.data);
            check("out_tkeep", 512'(out_tkeep), 512'(w.keep));
            check("out_tlast", 512'(out_tlast), 512'(w.last));
            if (out_tready) begin
              void'(exp_q.pop_front());
              n_out++;
              last_data = out_tdata;
              last_keep = out_tkeep;
              last_last = out_tlast;
            end
          end
        end
        stalled_prev = out_tvalid && !out_tready;
        if (pkt_valid) begin
          n_pkt++;
          last_bytes = pkt_bytes;
          if (exp_bytes_q.size() == 0) check("unexpected_pkt", 512'(pkt_valid), 512'(0));
          else check("pkt_bytes", 512'(pkt_bytes), 512'(exp_bytes_q.pop_front()));
        end
      end
    end
  end

  int          r1_n = 0;
  logic [31:0] r1_bytes;
  int          sat_n = 0;
  logic [7:0]  sat_bytes;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && r1_pkt_valid)  begin r1_n++;  r1_bytes  = r1_pkt_bytes;  end
      if (rst_n && sat_pkt_valid) begin sat_n++; sat_bytes = sat_pkt_bytes; end
    end
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int guard;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    in_tvalid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_tready && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    check("in_accept_timeout", 512'(in_tready), 512'(1));
    if (in_tready) model_beat(d, k, l);
    @(posedge clk);
    #1 in_tvalid = 1'b0;
  endtask

  task automatic send_full(input int n);
    for (int i = 0; i < n; i++)
      send({$urandom, $urandom}, 8'hFF, 1'(i == n - 1));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp_bytes_q.size() != 0 || out_tvalid) && guard < 4000) begin
      @(posedge clk);
      #1 guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_leftover", 512'(exp_q.size() + exp_bytes_q.size()), 512'(0));
  endtask

  function automatic logic [7:0] rand_keep();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return 8'hFF;
    if (r < 88) return 8'($urandom);
    return 8'h00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int           b0, p0, len;
    logic [63:0]  r1_d[4];
    logic [511:0] upper;

    rst_n = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
    r1_in_tvalid = 1'b0; r1_in_tdata = '0; r1_in_tkeep = '0; r1_in_tlast = 1'b0;
    r1_out_tready = 1'b1;
    sat_in_tvalid = 1'b0; sat_in_tdata = '0; sat_in_tkeep = '0; sat_in_tlast = 1'b0;
    sat_out_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, first cycle after reset
    @(negedge clk);
    check("rst_out_tvalid", 512'(out_tvalid), 512'(0));
    check("rst_out_tkeep",  512'(out_tkeep),  512'(0));
    check("rst_out_tdata",  out_tdata,        512'(0));
    check("rst_out_tlast",  512'(out_tlast),  512'(0));
    check("rst_pkt_valid",  512'(pkt_valid),  512'(0));
    check("rst_pkt_bytes",  512'(pkt_bytes),  512'(0));
    check("rst_in_tready",  512'(in_tready),  512'(1));
    @(posedge clk);
    #1;

    // 16 full beats -> 2 full wide beats, 128 bytes
    b0 = n_out; p0 = n_pkt;
    send_full(16);
    wait_drain();
    check("t16_beats", 512'(n_out - b0), 512'(2));
    check("t16_pkts",  512'(n_pkt - p0), 512'(1));
    check("t16_keep",  512'(last_keep),  512'({64{1'b1}}));
    check("t16_last",  512'(last_last),  512'(1));
    check("t16_bytes", 512'(last_bytes), 512'(128));

    // 3 full beats with tlast -> one partial beat, 24 bytes
    b0 = n_out;
    send_full(3);
    wait_drain();
    upper = last_data >> 192;
    check("t3_beats", 512'(n_out - b0), 512'(1));
    check("t3_keep",  512'(last_keep),  512'(64'h0000_0000_00FF_FFFF));
    check("t3_upper", upper,            512'(0));
    check("t3_bytes", 512'(last_bytes), 512'(24));

    // back-to-back packets of 8 + 8 beats
    b0 = n_out; p0 = n_pkt;
    send_full(8);
    send_full(8);
    wait_drain();
    check("b2b_beats", 512'(n_out - b0), 512'(2));
    check("b2b_pkts",  512'(n_pkt - p0), 512'(2));
    check("b2b_bytes", 512'(last_bytes), 512'(64));

    // null beat with tlast at lane 0
    b0 = n_out;
    send('0, 8'h00, 1'b1);
    wait_drain();
    check("null_beats", 512'(n_out - b0), 512'(1));
    check("null_keep",  512'(last_keep),  512'(0));
    check("null_last",  512'(last_last),  512'(1));
    check("null_bytes", 512'(last_bytes), 512'(0));

    // mid-beat null beats without tlast are dropped
    b0 = n_out;
    send({$urandom, $urandom}, 8'hFF, 1'b0);
    send({$urandom, $urandom}, 8'hFF, 1'b0);
    send({$urandom, $urandom}, 8'h00, 1'b0);
    send({$urandom, $urandom}, 8'hFF, 1'b0);
    send({$urandom, $urandom}, 8'h00, 1'b0);
    send({$urandom, $urandom}, 8'hFF, 1'b1);
    wait_drain();
    check("midnull_beats", 512'(n_out - b0), 512'(1));
    check("midnull_keep",  512'(last_keep),  512'(64'h0000_0000_FFFF_FFFF));
    check("midnull_bytes", 512'(last_bytes), 512'(32));

    // reset mid-packet discards the partial beat and count
    b0 = n_out; p0 = n_pkt;
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 8'hFF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    send_full(8);
    wait_drain();
    check("rst_mid_beats", 512'(n_out - b0), 512'(1));
    check("rst_mid_pkts",  512'(n_pkt - p0), 512'(1));
    check("rst_mid_bytes", 512'(last_bytes), 512'(64));

    // 1000 random packets with a randomly stalling sink
    rand_ready = 1;
    p0 = n_pkt;
    for (int p = 0; p < 1000; p++) begin
      len = int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send({$urandom, $urandom}, rand_keep(), 1'(i == len - 1));
      end
    end
    wait_drain();
    rand_ready = 0;
    check("rand_pkts", 512'(n_pkt - p0), 512'(1000));

    // RATIO=1: each beat appears one cycle after acceptance
    for (int i = 0; i < 4; i++) r1_d[i] = {$urandom, $urandom};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        r1_in_tdata  = r1_d[i];
        r1_in_tkeep  = 8'hFF;
        r1_in_tlast  = 1'(i == 3);
        r1_in_tvalid = 1'b1;
      end else begin
        r1_in_tvalid = 1'b0;
      end
      @(negedge clk);
      if (i == 0) begin
        check("r1_idle_valid", 512'(r1_out_tvalid), 512'(0));
      end else begin
        check("r1_valid", 512'(r1_out_tvalid), 512'(1));
        check("r1_data",  512'(r1_out_tdata),  512'(r1_d[i-1]));
        check("r1_keep",  512'(r1_out_tkeep),  512'(8'hFF));
        check("r1_last",  512'(r1_out_tlast),  512'(i == 4));
      end
      if (i < 4) check("r1_ready", 512'(r1_in_tready), 512'(1));
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("r1_pkts",  512'(r1_n),     512'(1));
    check("r1_bytes", 512'(r1_bytes), 512'(32));

    // CNT_BITS=8 with a 300-byte packet saturates at 255
    for (int i = 0; i < 38; i++) begin
      sat_in_tdata  = {$urandom, $urandom};
      sat_in_tkeep  = (i == 37) ? 8'h0F : 8'hFF;
      sat_in_tlast  = 1'(i == 37);
      sat_in_tvalid = 1'b1;
      @(negedge clk);
      if (!sat_in_tready) check("sat_ready", 512'(sat_in_tready), 512'(1));
      @(posedge clk);
      #1;
    end
    sat_in_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_pkts",  512'(sat_n),     512'(1));
    check("sat_bytes", 512'(sat_bytes), 512'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
